// File: rtl/decoders.sv
// decoders: registered 3-to-8 one-hot decoder with valid/ready intake,
// a programmable hold time per output line, and an auto-scan mode that
// walks all eight lines in turn (LED/digit strobing).
module decoders #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       scan_en,
  input  logic       in_valid,
  input  logic [2:0] binary_in,
  output logic       in_ready,
  output logic [7:0] decoder_out,
  output logic       out_valid,
  output logic       done
);

  // The counter runs from HOLD_CYCLES-1 down to 0, so each line is high
  // for exactly HOLD_CYCLES cycles. Legal values are 1..255.
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] scan_idx_q, scan_idx_d;
  logic [7:0] dec_q, dec_d;
  logic       out_valid_q;
  logic       done_q, done_d;
  logic [2:0] scan_next;

  // Codes are only taken in IDLE, and scan requests outrank them.
  assign in_ready    = (state_q == IDLE) & enable & ~scan_en & ~reset;
  assign decoder_out = dec_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;

  // Next-state and next-output selection; enable low overrides every state.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    scan_idx_d = scan_idx_q;
    dec_d      = dec_q;
    done_d     = 1'b0;
    scan_next  = scan_idx_q + 3'd1;

    if (!enable) begin
      state_d = IDLE;
      dec_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (scan_en) begin
            state_d    = SCAN;
            scan_idx_d = 3'd0;
            dec_d      = 8'h01;
            hold_cnt_d = HOLD_RELOAD;
          end else if (in_valid) begin
            state_d    = HOLD;
            dec_d      = 8'd1 << binary_in;
            hold_cnt_d = HOLD_RELOAD;
          end else begin
            dec_d = '0;
          end
        end

        HOLD: begin
          if (hold_cnt_q != 8'd0) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
          end else begin
            state_d = IDLE;
            dec_d   = '0;
            done_d  = 1'b1;
          end
        end

        SCAN: begin
          if (!scan_en) begin
            state_d = IDLE;
            dec_d   = '0;
          end else if (hold_cnt_q != 8'd0) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
          end else begin
            scan_idx_d = scan_next;
            dec_d      = 8'd1 << scan_next;
            hold_cnt_d = HOLD_RELOAD;
          end
        end

        default: begin
          state_d = IDLE;
          dec_d   = '0;
        end
      endcase
    end
  end

  // State and output registers; out_valid is derived from the same next value as decoder_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      scan_idx_q  <= '0;
      dec_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      scan_idx_q  <= scan_idx_d;
      dec_q       <= dec_d;
      out_valid_q <= |dec_d;
      done_q      <= done_d;
    end
  end

  // The output is never multi-hot.
  a_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(decoder_out));

  // out_valid always mirrors a non-zero output.
  a_valid: assert property (@(posedge clk) disable iff (reset)
    out_valid == (|decoder_out));

  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (reset)
    done |=> !done);

endmodule

// File: tb/tb_decoders.sv
// tb_decoders: table-driven bench for decoders. Each record holds the inputs
// for one cycle, the in_ready expected during that cycle, and the registered
// outputs expected in the following cycle. Expected outputs go into a
// scoreboard queue when the inputs are driven and are popped after the edge.
module tb_decoders;

  typedef struct {
    logic       rst;
    logic       en;
    logic       sc;
    logic       iv;
    logic [2:0] bin;
    logic       expReady;
    logic [7:0] expDec;
    logic       expDone;
  } vec_t;

  typedef struct {
    logic [7:0] dec;
    logic       done;
    int         idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       scanEn;
  logic       inValid;
  logic [2:0] binaryIn;

  logic       ready4, valid4, done4;
  logic [7:0] dec4;
  logic       ready1, valid1, done1;
  logic [7:0] dec1;

  logic       sel;
  logic       curReady, curValid, curDone;
  logic [7:0] curDec;

  vec_t  vecs[$];
  exp_t  sb[$];
  int    compared   = 0;
  int    mismatched = 0;
  string testName   = "init";

  always #5 clk = ~clk;

  decoders #(.HOLD_CYCLES(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .scan_en    (scanEn),
    .in_valid   (inValid),
    .binary_in  (binaryIn),
    .in_ready   (ready4),
    .decoder_out(dec4),
    .out_valid  (valid4),
    .done       (done4)
  );

  decoders #(.HOLD_CYCLES(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .scan_en    (scanEn),
    .in_valid   (inValid),
    .binary_in  (binaryIn),
    .in_ready   (ready1),
    .decoder_out(dec1),
    .out_valid  (valid1),
    .done       (done1)
  );

  assign curReady = sel ? ready1 : ready4;
  assign curDec   = sel ? dec1   : dec4;
  assign curValid = sel ? valid1 : valid4;
  assign curDone  = sel ? done1  : done4;

  function automatic logic [7:0] lineOf(input int k);
    logic [7:0] one;
    one = 8'd1;
    return one << (k % 8);
  endfunction

  task automatic addVec(input logic rst, input logic en, input logic sc,
                        input logic iv, input logic [2:0] bin,
                        input logic r, input logic [7:0] d, input logic dn);
    vec_t v;
    v.rst = rst; v.en = en; v.sc = sc; v.iv = iv; v.bin = bin;
    v.expReady = r; v.expDec = d; v.expDone = dn;
    vecs.push_back(v);
  endtask

  task automatic addScan(input int n, input int holdCycles);
    for (int i = 0; i < n; i++) addVec(0, 1, 1, 0, 3'd0, 0, lineOf(i / holdCycles), 0);
  endtask

  task automatic check(input string what, input int idx,
                       input logic [7:0] got, input logic [7:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s %s[%0d] got %h want %h", testName, what, idx, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    reset    = v.rst;
    enable   = v.en;
    scanEn   = v.sc;
    inValid  = v.iv;
    binaryIn = v.bin;
    #2;
    check("in_ready", idx, 8'(curReady), 8'(v.expReady));
    e.dec  = v.expDec;
    e.done = v.expDone;
    e.idx  = idx;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s scoreboard got empty want entry", testName);
      return;
    end
    e = sb.pop_front();
    check("decoder_out", e.idx, curDec, e.dec);
    check("out_valid", e.idx, 8'(curValid), 8'(|e.dec));
    check("done", e.idx, 8'(curDone), 8'(e.done));
  endtask

  task automatic runTable(input string name);
    testName = name;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
      @(posedge clk);
      #1;
      checkOutput();
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sel      = 1'b0;
    reset    = 1'b1;
    enable   = 1'b1;
    scanEn   = 1'b0;
    inValid  = 1'b0;
    binaryIn = 3'd0;

    // Reset held two cycles with a code offered: nothing accepted until it drops.
    addVec(1, 1, 0, 1, 3'd3, 0, 8'h00, 0);
    addVec(1, 1, 0, 1, 3'd3, 0, 8'h00, 0);
    addVec(0, 1, 0, 1, 3'd3, 1, 8'h08, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h08, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h08, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h08, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h00, 1);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    runTable("reset");

    // Single decode of 5, then done pulse and done clearing.
    addVec(0, 1, 0, 1, 3'd5, 1, 8'h20, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h20, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h20, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h20, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h00, 1);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    runTable("single");

    // Back-to-back: in_valid held high, code changes during HOLD.
    addVec(0, 1, 0, 1, 3'd0, 1, 8'h01, 0);
    addVec(0, 1, 0, 1, 3'd0, 0, 8'h01, 0);
    addVec(0, 1, 0, 1, 3'd7, 0, 8'h01, 0);
    addVec(0, 1, 0, 1, 3'd7, 0, 8'h01, 0);
    addVec(0, 1, 0, 1, 3'd7, 0, 8'h00, 1);
    addVec(0, 1, 0, 1, 3'd7, 1, 8'h80, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h80, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h80, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h80, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h00, 1);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    runTable("b2b");

    // Full sweep plus wrap back to line 0, then scan_en drops.
    addScan(33, 4);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h00, 0);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    runTable("scan_full");

    // scan_en dropped in cycle 10, in the middle of a line's hold.
    addScan(10, 4);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h00, 0);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    runTable("scan_drop");

    // Enable dropped mid-HOLD, while idle with a code, and mid-SCAN.
    addVec(0, 1, 0, 1, 3'd2, 1, 8'h04, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h04, 0);
    addVec(0, 0, 0, 0, 3'd0, 0, 8'h00, 0);
    addVec(0, 0, 0, 0, 3'd0, 0, 8'h00, 0);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    addVec(0, 0, 0, 1, 3'd1, 0, 8'h00, 0);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    addScan(3, 4);
    addVec(0, 0, 1, 0, 3'd0, 0, 8'h00, 0);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    runTable("abort");

    // Reset mid-scan: the sweep restarts at line 0.
    addScan(6, 4);
    addVec(1, 1, 1, 0, 3'd0, 0, 8'h00, 0);
    addScan(5, 4);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h00, 0);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    runTable("reset_scan");

    // scan_en during HOLD waits for the idle cycle; scan beats in_valid in IDLE.
    addVec(0, 1, 0, 1, 3'd6, 1, 8'h40, 0);
    addVec(0, 1, 1, 0, 3'd0, 0, 8'h40, 0);
    addVec(0, 1, 1, 0, 3'd0, 0, 8'h40, 0);
    addVec(0, 1, 1, 0, 3'd0, 0, 8'h40, 0);
    addVec(0, 1, 1, 0, 3'd0, 0, 8'h00, 1);
    addVec(0, 1, 1, 1, 3'd6, 0, 8'h01, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h00, 0);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    runTable("scan_vs_hold");

    // HOLD_CYCLES=1 instance: single-cycle pulses and one line per cycle in scan.
    sel = 1'b1;
    addVec(1, 1, 0, 0, 3'd0, 0, 8'h00, 0);
    addVec(0, 1, 0, 1, 3'd3, 1, 8'h08, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h00, 1);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    addVec(0, 1, 0, 1, 3'd1, 1, 8'h02, 0);
    addVec(0, 1, 0, 1, 3'd1, 0, 8'h00, 1);
    addVec(0, 1, 0, 1, 3'd1, 1, 8'h02, 0);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h00, 1);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    addScan(9, 1);
    addVec(0, 1, 0, 0, 3'd0, 0, 8'h00, 0);
    addVec(0, 1, 0, 0, 3'd0, 1, 8'h00, 0);
    runTable("hold1");

    testName = "final";
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL final scoreboard got %0d entries want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
